// File: rtl/mul_ln2_pkg.sv
// Shared FPU constants for the ln2 scaling unit.
// Field widths, the ln2 mantissa and the all-ones exponent.
package mul_ln2_pkg;
  localparam int FP_WIDTH   = 32;
  localparam int FP_EXPO    = 8;
  localparam int FP_MANT    = 23;
  localparam int SIG_WIDTH  = FP_MANT + 1;
  localparam int PROD_WIDTH = 2 * SIG_WIDTH;

  // ln2 = 0.693147..., as 1.23 fixed point scaled by 2
  localparam logic [SIG_WIDTH-1:0] LN2_MANT = 24'hB17218;
  localparam logic [FP_EXPO-1:0]   EXPO_ONES = 8'hFF;
endpackage

// File: rtl/mul_ln2_if.sv
// Operand/result valid-ready stream bundle for mul_ln2.
// master drives operands and accepts results; slave is the unit.
interface mul_ln2_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  vld_in;
    logic                  rdy_in;
    logic [DATA_WIDTH-1:0] Oprand_A_D;
    logic [DATA_WIDTH-1:0] Result_out;
    logic                  vld_out;
    logic                  rdy_out;

    modport master (
        output vld_in, Oprand_A_D, rdy_out,
        input  rdy_in, Result_out, vld_out
    );

    modport slave (
        input  vld_in, Oprand_A_D, rdy_out,
        output rdy_in, Result_out, vld_out
    );
endinterface

// File: rtl/mul_ln2_mant_mult.sv
// Constant multiply of a 1.23 significand by the ln2 mantissa.
// Pure shift-add over the set bits of the constant.
module ln2_mant_mult
    import mul_ln2_pkg::*;
(
    input  logic [SIG_WIDTH-1:0]  a,
    output logic [PROD_WIDTH-1:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < SIG_WIDTH; i++) begin
            if (LN2_MANT[i])
                p = p + ({{SIG_WIDTH{1'b0}}, a} << i);
        end
    end
endmodule

// File: rtl/mul_ln2.sv
// FP32 x*ln2, two-stage valid/ready pipeline.
// Stage0 holds the operand, stage1 holds the rounded-down result.
module mul_ln2
    import mul_ln2_pkg::*;
#(
    parameter int DATA_WIDTH = FP_WIDTH,
    parameter int EXPO_WIDTH = FP_EXPO,
    parameter int MANT_WIDTH = FP_MANT
) (
    input logic    clk,
    input logic    rst,
    input logic    en,
    mul_ln2_if.slave io
);
    localparam int MW = MANT_WIDTH;
    localparam int EW = EXPO_WIDTH;
    localparam logic [EW-1:0] ONES = EW'(EXPO_ONES);

    logic                  s0_vld;
    logic [DATA_WIDTH-1:0] s0_data;
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_free;
    logic                  s0_open;

    logic                  sign;
    logic [EW-1:0]         expo;
    logic [EW-1:0]         expo_r;
    logic [MW:0]           sig;
    logic [2*MW+1:0]       prod;
    logic                  shift;
    logic [MW-1:0]         mant;
    logic [DATA_WIDTH-1:0] res;

    assign s1_free = ~s1_vld | io.rdy_out;
    assign s0_open = ~s0_vld | s1_free;

    assign io.rdy_in     = en & ~rst & s0_open;
    assign io.vld_out    = s1_vld;
    assign io.Result_out = s1_data;

    assign sign = s0_data[DATA_WIDTH-1];
    assign expo = s0_data[DATA_WIDTH-2 -: EW];
    assign sig  = {1'b1, s0_data[MW-1:0]};

    ln2_mant_mult u_mult (
        .a (sig),
        .p (prod)
    );

    // Product is in [0.69, 1.39): at most one bit of normalisation
    assign shift  = prod[2*MW+1];
    assign mant   = shift ? prod[2*MW:MW+1] : prod[2*MW-1:MW];
    assign expo_r = expo - EW'(1) + EW'(shift);

    always_comb begin
        res = {sign, expo_r, mant};
        unique case (1'b1)
            (expo == '0): res = {sign, {(DATA_WIDTH-1){1'b0}}};
            (expo == ONES): res = {sign, ONES, {MW{1'b0}}};
            (expo == EW'(1) && !shift):
                res = {sign, {(DATA_WIDTH-1){1'b0}}};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld  <= 1'b0;
            s0_data <= '0;
        end else if (en && s0_open) begin
            s0_vld <= io.vld_in;
            if (io.vld_in)
                s0_data <= io.Oprand_A_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else if (en && s1_free) begin
            s1_vld <= s0_vld;
            if (s0_vld)
                s1_data <= res;
        end
    end
endmodule
